// File: rtl/node_rx_sink.sv
`default_nettype none
// node_rx_sink: network port sink with LFSR enable throttle, misroute check and phase statistics.
// Optional RX_WATCHDOG_EN adds an idle watchdog that forces the DONE phase.

localparam int X_NODES = 4;
localparam int Y_NODES = 4;
localparam int XW = $clog2(X_NODES + 1);
localparam int YW = $clog2(Y_NODES + 1);

typedef struct packed {
  logic [XW-1:0] x_dest;
  logic [YW-1:0] y_dest;
  logic [XW-1:0] x_source;
  logic [YW-1:0] y_source;
  logic [15:0]   payload;
} packet_t;

module node_rx_sink #(
  parameter logic [XW-1:0] X_LOC           = '0,
  parameter logic [YW-1:0] Y_LOC           = '0,
  parameter int            EN_THRESH       = 256,
  parameter logic [7:0]    LFSR_SEED       = 8'hA5,
  parameter int            WARMUP_PACKETS  = 1000,
  parameter int            MEASURE_PACKETS = 5000,
  parameter int            DRAIN_PACKETS   = 3000,
  parameter int            CNT_W           = 32,
  parameter int            TIMEOUT_CYCLES  = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  packet_t          i_data,
  input  logic             i_data_val,
  output logic             o_en,
  output logic [1:0]       o_phase,
  output logic [CNT_W-1:0] o_rx_count,
  output logic [CNT_W-1:0] o_meas_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_err,
  output logic [XW-1:0]    o_err_x_src,
  output logic [YW-1:0]    o_err_y_src,
  output logic             o_done,
  output logic             o_timeout
);

  typedef enum logic [1:0] {
    WARMUP  = 2'd0,
    MEASURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } phase_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  phase_e           phase_q, phase_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             en_q, en_d;
  logic [CNT_W-1:0] rx_q, rx_d, meas_q, meas_d, errc_q, errc_d, pcnt_q, pcnt_d;
  logic             err_q, err_d, done_q, done_d, to_q, to_d;
  logic [XW-1:0]    esx_q, esx_d;
  logic [YW-1:0]    esy_q, esy_d;

  logic             accept, misroute, limit_hit;
  logic [CNT_W:0]   pcnt_sum;
  logic [63:0]      limit;

`ifdef RX_WATCHDOG_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          idle_inc;
  logic          unused_payload;
  assign unused_payload = ^i_data.payload;
`else
  logic          unused_cfg;
  assign unused_cfg = ^{i_data.payload, TIMEOUT_CYCLES};
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    accept   = i_data_val & en_q;
    misroute = (i_data.x_dest != X_LOC) || (i_data.y_dest != Y_LOC);

    // Taps x^8+x^6+x^5+x^4+1 on the shift-left register
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    en_d   = int'(lfsr_q) < EN_THRESH;

    rx_d   = accept ? sat_inc(rx_q) : rx_q;
    meas_d = (accept && phase_q == MEASURE) ? sat_inc(meas_q) : meas_q;
    errc_d = (accept && misroute) ? sat_inc(errc_q) : errc_q;
    err_d  = err_q | (accept & misroute);
    esx_d  = esx_q;
    esy_d  = esy_q;
    if (accept && misroute && !err_q) begin
      esx_d = i_data.x_source;
      esy_d = i_data.y_source;
    end

    case (phase_q)
      WARMUP:  limit = 64'(WARMUP_PACKETS);
      MEASURE: limit = 64'(MEASURE_PACKETS);
      default: limit = 64'(DRAIN_PACKETS);
    endcase

    // A zero limit is met without any accept, so the phase steps on its own
    pcnt_sum  = {1'b0, pcnt_q} + {{CNT_W{1'b0}}, accept};
    limit_hit = (phase_q != DONE) && (64'(pcnt_sum) >= limit);
    pcnt_d    = pcnt_sum[CNT_W] ? CNT_MAX : pcnt_sum[CNT_W-1:0];
    phase_d   = phase_q;
    if (limit_hit) begin
      phase_d = phase_e'(phase_q + 2'd1);
      pcnt_d  = '0;
    end
    to_d = to_q;

`ifdef RX_WATCHDOG_EN
    idle_inc = (phase_q == MEASURE || phase_q == DRAIN) && !accept && !limit_hit;
    idle_d   = idle_inc ? idle_q + IW'(1) : '0;
    if (idle_inc && int'(idle_d) >= TIMEOUT_CYCLES) begin
      to_d    = 1'b1;
      phase_d = DONE;
      pcnt_d  = '0;
      idle_d  = '0;
    end
`endif

    done_d = (phase_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= WARMUP;
      lfsr_q  <= LFSR_SEED;
      en_q    <= 1'b0;
      rx_q    <= '0;
      meas_q  <= '0;
      errc_q  <= '0;
      pcnt_q  <= '0;
      err_q   <= 1'b0;
      esx_q   <= '0;
      esy_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
`ifdef RX_WATCHDOG_EN
      idle_q  <= '0;
`endif
    end else begin
      phase_q <= phase_d;
      lfsr_q  <= lfsr_d;
      en_q    <= en_d;
      rx_q    <= rx_d;
      meas_q  <= meas_d;
      errc_q  <= errc_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      esx_q   <= esx_d;
      esy_q   <= esy_d;
      done_q  <= done_d;
      to_q    <= to_d;
`ifdef RX_WATCHDOG_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign o_en         = en_q;
  assign o_phase      = phase_q;
  assign o_rx_count   = rx_q;
  assign o_meas_count = meas_q;
  assign o_err_count  = errc_q;
  assign o_err        = err_q;
  assign o_err_x_src  = esx_q;
  assign o_err_y_src  = esy_q;
  assign o_done       = done_q;
  assign o_timeout    = to_q;

endmodule

`default_nettype wire

// File: tb/tb_node_rx_sink.sv
`default_nettype none
// tb_node_rx_sink: vector table, directed corner sequences and randomized model check for node_rx_sink.

module tb_node_rx_sink;

  // 0: full rate (1,2) 3/5/2, 1: random throttle 128, 2: never enabled, 3: zero limits, 4: 4-bit counters
  logic          clk = 1'b0;
  logic          rst [5];
  logic          val [5];
  packet_t       din [5];
  logic          en  [5];
  logic [1:0]    ph  [5];
  logic          err [5];
  logic [XW-1:0] exs [5];
  logic [YW-1:0] eys [5];
  logic          dn  [5];
  logic          to  [5];
  logic [31:0]   rx  [4];
  logic [31:0]   mc  [4];
  logic [31:0]   ec  [4];
  logic [3:0]    rx_s, mc_s, ec_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  node_rx_sink #(.X_LOC(3'd1), .Y_LOC(3'd2), .EN_THRESH(256), .WARMUP_PACKETS(3),
                 .MEASURE_PACKETS(5), .DRAIN_PACKETS(2), .CNT_W(32), .TIMEOUT_CYCLES(16)) u_a (
    .clk(clk), .reset(rst[0]), .i_data(din[0]), .i_data_val(val[0]), .o_en(en[0]),
    .o_phase(ph[0]), .o_rx_count(rx[0]), .o_meas_count(mc[0]), .o_err_count(ec[0]),
    .o_err(err[0]), .o_err_x_src(exs[0]), .o_err_y_src(eys[0]), .o_done(dn[0]), .o_timeout(to[0]));

  node_rx_sink #(.X_LOC(3'd2), .Y_LOC(3'd3), .EN_THRESH(128), .WARMUP_PACKETS(20),
                 .MEASURE_PACKETS(60), .DRAIN_PACKETS(40), .CNT_W(32)) u_r (
    .clk(clk), .reset(rst[1]), .i_data(din[1]), .i_data_val(val[1]), .o_en(en[1]),
    .o_phase(ph[1]), .o_rx_count(rx[1]), .o_meas_count(mc[1]), .o_err_count(ec[1]),
    .o_err(err[1]), .o_err_x_src(exs[1]), .o_err_y_src(eys[1]), .o_done(dn[1]), .o_timeout(to[1]));

  node_rx_sink #(.X_LOC(3'd1), .Y_LOC(3'd2), .EN_THRESH(0), .CNT_W(32)) u_z (
    .clk(clk), .reset(rst[2]), .i_data(din[2]), .i_data_val(val[2]), .o_en(en[2]),
    .o_phase(ph[2]), .o_rx_count(rx[2]), .o_meas_count(mc[2]), .o_err_count(ec[2]),
    .o_err(err[2]), .o_err_x_src(exs[2]), .o_err_y_src(eys[2]), .o_done(dn[2]), .o_timeout(to[2]));

  node_rx_sink #(.X_LOC(3'd1), .Y_LOC(3'd2), .EN_THRESH(256), .WARMUP_PACKETS(0),
                 .MEASURE_PACKETS(0), .DRAIN_PACKETS(0), .CNT_W(32)) u_l (
    .clk(clk), .reset(rst[3]), .i_data(din[3]), .i_data_val(val[3]), .o_en(en[3]),
    .o_phase(ph[3]), .o_rx_count(rx[3]), .o_meas_count(mc[3]), .o_err_count(ec[3]),
    .o_err(err[3]), .o_err_x_src(exs[3]), .o_err_y_src(eys[3]), .o_done(dn[3]), .o_timeout(to[3]));

  node_rx_sink #(.X_LOC(3'd1), .Y_LOC(3'd2), .EN_THRESH(256), .WARMUP_PACKETS(3),
                 .MEASURE_PACKETS(5), .DRAIN_PACKETS(2), .CNT_W(4)) u_s (
    .clk(clk), .reset(rst[4]), .i_data(din[4]), .i_data_val(val[4]), .o_en(en[4]),
    .o_phase(ph[4]), .o_rx_count(rx_s), .o_meas_count(mc_s), .o_err_count(ec_s),
    .o_err(err[4]), .o_err_x_src(exs[4]), .o_err_y_src(eys[4]), .o_done(dn[4]), .o_timeout(to[4]));

  typedef struct {
    bit            v;
    logic [XW-1:0] xd;
    logic [YW-1:0] yd;
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    logic [1:0]    ph;
    int            rx;
    int            meas;
    int            errc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic packet_t mkpkt(input logic [XW-1:0] xd, input logic [YW-1:0] yd,
                                    input logic [XW-1:0] xs, input logic [YW-1:0] ys);
    packet_t p;
    p.x_dest   = xd;
    p.y_dest   = yd;
    p.x_source = xs;
    p.y_source = ys;
    p.payload  = 16'($urandom);
    return p;
  endfunction

  function automatic vec_t mkv(input bit v, input int xd, input int yd, input int xs, input int ys,
                               input int p, input int r, input int m, input int e);
    vec_t t;
    t.v = v; t.xd = XW'(xd); t.yd = YW'(yd); t.xs = XW'(xs); t.ys = YW'(ys);
    t.ph = 2'(p); t.rx = r; t.meas = m; t.errc = e;
    return t;
  endfunction

  // Maximal-length sequence of x^8+x^6+x^5+x^4+1: feedback is the parity of bits 8,6,5,4
  function automatic int lfsr_step(input int s);
    int fb;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    return ((s * 2) + fb) % 256;
  endfunction

  task automatic chk_reset(input int i, input string tag);
    chk({tag, "_en"},   64'(en[i]),  64'(0));
    chk({tag, "_ph"},   64'(ph[i]),  64'(0));
    chk({tag, "_rx"},   64'(rx[i]),  64'(0));
    chk({tag, "_meas"}, 64'(mc[i]),  64'(0));
    chk({tag, "_errc"}, 64'(ec[i]),  64'(0));
    chk({tag, "_err"},  64'(err[i]), 64'(0));
    chk({tag, "_exs"},  64'(exs[i]), 64'(0));
    chk({tag, "_eys"},  64'(eys[i]), 64'(0));
    chk({tag, "_done"}, 64'(dn[i]),  64'(0));
    chk({tag, "_to"},   64'(to[i]),  64'(0));
  endtask

  initial begin
    int   m_lfsr, m_acc, m_errc, duty, cnt, exp_ph, exp_meas;
    bit   m_en, m_seen;
    logic [XW-1:0] m_xs;
    logic [YW-1:0] m_ys;

    for (int i = 0; i < 5; i++) begin
      rst[i] = 1'b1;
      val[i] = 1'b0;
      din[i] = '0;
    end

    // Full-rate run followed by two misroutes after DONE, with one idle step mid-run
    tbl.push_back(mkv(1, 1, 2, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 0, 2, 0, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 1, 3, 0, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 1, 4, 1, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 1, 5, 2, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 0, 1, 5, 2, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 1, 6, 3, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 1, 7, 4, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 2, 8, 5, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 2, 9, 5, 0));
    tbl.push_back(mkv(1, 1, 2, 0, 0, 3, 10, 5, 0));
    tbl.push_back(mkv(1, 0, 2, 3, 1, 3, 11, 5, 1));
    tbl.push_back(mkv(1, 1, 0, 2, 2, 3, 12, 5, 2));

    tick(); tick();
    chk_reset(0, "reset");

    rst[0] = 1'b0;
    tick();
    chk("first_en", 64'(en[0]), 64'(1));
    foreach (tbl[k]) begin
      val[0] = tbl[k].v;
      din[0] = mkpkt(tbl[k].xd, tbl[k].yd, tbl[k].xs, tbl[k].ys);
      tick();
      chk($sformatf("vec%0d_ph", k),   64'(ph[0]), 64'(tbl[k].ph));
      chk($sformatf("vec%0d_rx", k),   64'(rx[0]), 64'(tbl[k].rx));
      chk($sformatf("vec%0d_meas", k), 64'(mc[0]), 64'(tbl[k].meas));
      chk($sformatf("vec%0d_errc", k), 64'(ec[0]), 64'(tbl[k].errc));
      chk($sformatf("vec%0d_done", k), 64'(dn[0]), 64'(tbl[k].ph == 2'd3));
    end
    val[0] = 1'b0;
    chk("mis_err", 64'(err[0]), 64'(1));
    chk("mis_exs", 64'(exs[0]), 64'(3));
    chk("mis_eys", 64'(eys[0]), 64'(1));
    chk("mis_to",  64'(to[0]),  64'(0));

    // Reset during MEASURE, with a packet held valid through reset and release
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; tick();
    for (int k = 0; k < 6; k++) begin
      val[0] = 1'b1;
      din[0] = mkpkt(3'd1, 3'd2, 3'd0, 3'd0);
      tick();
    end
    chk("pre_rst_rx", 64'(rx[0]), 64'(6));
    chk("pre_rst_ph", 64'(ph[0]), 64'(1));
    rst[0] = 1'b1;
    tick();
    chk_reset(0, "midrst");
    tick();
    rst[0] = 1'b0;
    tick();
    chk("rel_rx", 64'(rx[0]), 64'(0));
    for (int k = 0; k < 3; k++) tick();
    val[0] = 1'b0;
    chk("rerun_rx", 64'(rx[0]), 64'(3));
    chk("rerun_ph", 64'(ph[0]), 64'(1));

    // Stall in MEASURE
    for (int k = 0; k < 15; k++) tick();
    chk("stall15_ph", 64'(ph[0]), 64'(1));
    chk("stall15_to", 64'(to[0]), 64'(0));
    tick();
`ifdef RX_WATCHDOG_EN
    chk("stall16_ph",   64'(ph[0]), 64'(3));
    chk("stall16_to",   64'(to[0]), 64'(1));
    chk("stall16_done", 64'(dn[0]), 64'(1));
`else
    chk("stall16_ph",   64'(ph[0]), 64'(1));
    chk("stall16_to",   64'(to[0]), 64'(0));
    chk("stall16_done", 64'(dn[0]), 64'(0));
`endif

    // Never enabled
    rst[2] = 1'b0;
    val[2] = 1'b1;
    din[2] = mkpkt(3'd1, 3'd2, 3'd0, 3'd0);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      cnt += int'(en[2]);
    end
    val[2] = 1'b0;
    chk("thr0_en_cycles", 64'(cnt), 64'(0));
    chk("thr0_rx", 64'(rx[2]), 64'(0));

    // Zero limits step one phase per cycle
    rst[3] = 1'b0;
    tick(); chk("lim0_c1", 64'(ph[3]), 64'(1));
    tick(); chk("lim0_c2", 64'(ph[3]), 64'(2));
    tick(); chk("lim0_c3", 64'(ph[3]), 64'(3));
    chk("lim0_done", 64'(dn[3]), 64'(1));
    chk("lim0_rx",   64'(rx[3]), 64'(0));

    // 4-bit counters saturate
    rst[4] = 1'b0;
    tick();
    val[4] = 1'b1;
    din[4] = mkpkt(3'd1, 3'd2, 3'd0, 3'd0);
    for (int k = 0; k < 20; k++) tick();
    val[4] = 1'b0;
    chk("sat_rx",   64'(rx_s),  64'(15));
    chk("sat_meas", 64'(mc_s),  64'(5));
    chk("sat_ph",   64'(ph[4]), 64'(3));
    chk("sat_errc", 64'(ec_s),  64'(0));

    // Randomized traffic through the half-rate throttle against the model
    m_lfsr = 8'hA5; m_en = 1'b0; m_acc = 0; m_errc = 0; m_seen = 1'b0;
    m_xs = '0; m_ys = '0; duty = 0;
    rst[1] = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      bit v;
      logic [XW-1:0] xd, xs;
      logic [YW-1:0] yd, ys;
      v  = ($urandom_range(0, 3) != 0);
      xd = ($urandom_range(0, 5) == 0) ? XW'($urandom_range(0, 4)) : 3'd2;
      yd = ($urandom_range(0, 5) == 0) ? YW'($urandom_range(0, 4)) : 3'd3;
      xs = XW'($urandom_range(0, 4));
      ys = YW'($urandom_range(0, 4));
      val[1] = v;
      din[1] = mkpkt(xd, yd, xs, ys);
      tick();
      if (v && m_en) begin
        m_acc++;
        if (xd != 3'd2 || yd != 3'd3) begin
          m_errc++;
          if (!m_seen) begin
            m_seen = 1'b1;
            m_xs = xs;
            m_ys = ys;
          end
        end
      end
      m_en   = (m_lfsr < 128);
      m_lfsr = lfsr_step(m_lfsr);
      exp_ph   = (m_acc < 20) ? 0 : (m_acc < 80) ? 1 : (m_acc < 120) ? 2 : 3;
      exp_meas = (m_acc <= 20) ? 0 : (m_acc >= 80) ? 60 : m_acc - 20;
      chk("rnd_en",   64'(en[1]),  64'(m_en));
      chk("rnd_ph",   64'(ph[1]),  64'(exp_ph));
      chk("rnd_rx",   64'(rx[1]),  64'(m_acc));
      chk("rnd_meas", 64'(mc[1]),  64'(exp_meas));
      chk("rnd_errc", 64'(ec[1]),  64'(m_errc));
      chk("rnd_err",  64'(err[1]), 64'(m_seen));
      chk("rnd_exs",  64'(exs[1]), 64'(m_xs));
      chk("rnd_eys",  64'(eys[1]), 64'(m_ys));
      duty += int'(en[1]);
    end
    val[1] = 1'b0;
    chk("duty_in_range", 64'(duty >= 4500 && duty <= 5500), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
